uart_tx_serializer: RTL

- Consumes the 8-bit AXI-Stream byte stream produced by the AXI UART bridge FIFO (uart_axis_*).
- Serialises each byte onto a single UART TX line: 8N1 by default, LSB first, with a fixed integer baud divider.
- Sits between the UART bridge and the board TX pin. It is the line-side end of the byte stream.

---
 rtl/uart_tx_serializer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_serializer.sv
// UART transmitter: takes bytes over an AXI-Stream handshake and serialises them LSB first (8N1/8N2).
// Optional parity bit after the data bits when UART_TX_PARITY_EN is defined (PARITY_ODD selects odd/even).
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 868,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    output logic       uart_txd,
    output logic       busy
);

    // state  | meaning
    // IDLE   | line high, s_axis_tready=1, waiting for a byte
    // START  | start bit (txd=0)
    // DATA   | eight data bits, LSB first
    // PARITY | parity bit (only with UART_TX_PARITY_EN)
    // STOP   | STOP_BITS stop bits (txd=1)
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
`endif
    localparam logic [2:0] STOP   = 3'd4;

    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic          STOP_LAST = (STOP_BITS == 2);

    if (CLKS_PER_BIT < 2 || STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1)
    begin : g_param_check
        $error("uart_tx_serializer: illegal parameter value");
    end

    logic [2:0]    state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          stop_idx;
    logic          bit_done;
`ifdef UART_TX_PARITY_EN
    logic          parity_bit;
`endif

    assign bit_done = (baud_cnt == CNT_LAST);

    // Baud counter runs only inside a frame and restarts at every bit boundary.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            baud_cnt <= '0;
        end else if (state == IDLE || bit_done) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            bit_idx       <= '0;
            shreg         <= '0;
            stop_idx      <= 1'b0;
            uart_txd      <= 1'b1;
            s_axis_tready <= 1'b0;
            busy          <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (s_axis_tready && s_axis_tvalid) begin
                        state         <= START;
                        shreg         <= s_axis_tdata;
                        uart_txd      <= 1'b0;
                        busy          <= 1'b1;
                        s_axis_tready <= 1'b0;
`ifdef UART_TX_PARITY_EN
                        parity_bit    <= (^s_axis_tdata) ^ 1'(PARITY_ODD);
`endif
                    end else begin
                        uart_txd      <= 1'b1;
                        s_axis_tready <= 1'b1;
                    end
                end
                START: begin
                    if (bit_done) begin
                        state    <= DATA;
                        bit_idx  <= '0;
                        uart_txd <= shreg[0];
                        shreg    <= {1'b0, shreg[7:1]};
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state    <= PARITY;
                            uart_txd <= parity_bit;
`else
                            state    <= STOP;
                            uart_txd <= 1'b1;
                            stop_idx <= 1'b0;
`endif
                        end else begin
                            bit_idx  <= bit_idx + 3'd1;
                            uart_txd <= shreg[0];
                            shreg    <= {1'b0, shreg[7:1]};
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_done) begin
                        state    <= STOP;
                        uart_txd <= 1'b1;
                        stop_idx <= 1'b0;
                    end
                end
`endif
                STOP: begin
                    if (bit_done) begin
                        if (stop_idx == STOP_LAST) begin
                            state         <= IDLE;
                            busy          <= 1'b0;
                            s_axis_tready <= 1'b1;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end
                end
                default: begin
                    state         <= IDLE;
                    uart_txd      <= 1'b1;
                    busy          <= 1'b0;
                    s_axis_tready <= 1'b0;
                end
            endcase
        end
    end

endmodule
